// File: rtl/axi_read_arbiter.sv
// Shares one AXI read master between the I-cache and the D-cache. Each grant issues one
// line-aligned INCR burst, and R beats are steered to the owner until rlast is accepted.
module axi_read_arbiter #(
    parameter int BURST_LEN  = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_arvalid,
    input  logic [63:0]           ic_araddr,
    output logic                  ic_arready,
    output logic                  ic_rvalid,
    input  logic                  ic_rready,
    input  logic                  dc_arvalid,
    input  logic [63:0]           dc_araddr,
    output logic                  dc_arready,
    output logic                  dc_rvalid,
    input  logic                  dc_rready,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  rlast_out,
    output logic                  m_axi_arvalid,
    output logic [63:0]           m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic                  m_axi_rlast,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    output logic                  m_axi_rready,
    output logic                  instruction_cache_reading,
    output logic                  data_cache_reading
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] AR_IC = 3'd1;
    localparam logic [2:0] R_IC  = 3'd2;
    localparam logic [2:0] AR_DC = 3'd3;
    localparam logic [2:0] R_DC  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        last_dc_q, last_dc_d;
    logic [63:0] addr_q, addr_d;
    logic        ic_rd_q, dc_rd_q;
    logic        grant_ic, grant_dc, last_beat;
    logic        unused_addr_lsbs;

    // Line offset bits are dropped by the 64-byte alignment.
    assign unused_addr_lsbs = ^{ic_araddr[5:0], dc_araddr[5:0]};

    // On a tie the requester that did not own the last burst wins.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (state_q == IDLE) begin
            if (ic_arvalid && dc_arvalid) begin
                grant_ic = last_dc_q;
                grant_dc = !last_dc_q;
            end else begin
                grant_ic = ic_arvalid;
                grant_dc = dc_arvalid;
            end
        end
    end

    assign last_beat = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    always_comb begin
        state_d   = state_q;
        last_dc_d = last_dc_q;
        addr_d    = addr_q;
        case (state_q)
            IDLE: begin
                if (grant_ic) begin
                    state_d = AR_IC;
                    addr_d  = {ic_araddr[63:6], 6'b0};
                end else if (grant_dc) begin
                    state_d = AR_DC;
                    addr_d  = {dc_araddr[63:6], 6'b0};
                end
            end
            AR_IC: if (m_axi_arready) state_d = R_IC;
            AR_DC: if (m_axi_arready) state_d = R_DC;
            R_IC: begin
                if (last_beat) begin
                    state_d   = IDLE;
                    last_dc_d = 1'b0;
                end
            end
            R_DC: begin
                if (last_beat) begin
                    state_d   = IDLE;
                    last_dc_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Busy flags are registered from the next state so they track the FSM cycle-for-cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_dc_q <= 1'b0;
            addr_q    <= 64'h0;
            ic_rd_q   <= 1'b0;
            dc_rd_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_dc_q <= last_dc_d;
            addr_q    <= addr_d;
            ic_rd_q   <= (state_d == AR_IC) || (state_d == R_IC);
            dc_rd_q   <= (state_d == AR_DC) || (state_d == R_DC);
        end
    end

    assign ic_arready    = grant_ic;
    assign dc_arready    = grant_dc;
    assign m_axi_arvalid = (state_q == AR_IC) || (state_q == AR_DC);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;

    assign ic_rvalid     = (state_q == R_IC) && m_axi_rvalid;
    assign dc_rvalid     = (state_q == R_DC) && m_axi_rvalid;
    assign m_axi_rready  = ((state_q == R_IC) && ic_rready) || ((state_q == R_DC) && dc_rready);
    assign rdata_out     = m_axi_rdata;
    assign rlast_out     = m_axi_rlast;

    assign instruction_cache_reading = ic_rd_q;
    assign data_cache_reading        = dc_rd_q;
endmodule
